sa_nxn_engine: RTL and testbench

SA_NXN_ENGINE -- requirements
Module: sa_nxn_engine

---
 rtl/sa_pkg.sv | 25 ++
 rtl/sa_mac_pe.sv | 45 ++++
 rtl/sa_nxn_engine.sv | 183 ++++++++++++++++++
 tb/tb_sa_nxn_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the NxN systolic matrix-multiply engine:
// controller state encoding and the ceil(log2) helper used to size indices.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } sa_state_e;

  // Never returns less than 1 so that index ports are always at least one bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sa_mac_pe.sv
// One processing element of the systolic array: registered pass-through of the
// A operand (left to right) and B operand (top to bottom) plus a wrapping MAC.
module sa_mac_pe #(
  parameter int DW   = 8,
  parameter int ACCW = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [DW-1:0]   din,
  input  logic [DW-1:0]   win,
  output logic [DW-1:0]   dout,
  output logic [DW-1:0]   wout,
  output logic [ACCW-1:0] acc
);

  logic [DW-1:0]   dout_q;
  logic [DW-1:0]   wout_q;
  logic [ACCW-1:0] acc_q;
  logic [2*DW-1:0] prod;

  assign prod = (2*DW)'(din) * (2*DW)'(win);

  // Accumulation wraps modulo 2^ACCW; zeros flow through outside the feed window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      wout_q <= '0;
      acc_q  <= '0;
    end else if (clear) begin
      dout_q <= '0;
      wout_q <= '0;
      acc_q  <= '0;
    end else begin
      dout_q <= din;
      wout_q <= win;
      acc_q  <= acc_q + ACCW'(prod);
    end
  end

  assign dout = dout_q;
  assign wout = wout_q;
  assign acc  = acc_q;

endmodule

// File: rtl/sa_nxn_engine.sv
// NxN output-stationary systolic engine computing C = A x B from row-loaded
// operand buffers, then streaming C out one row at a time with a ready handshake.
module sa_nxn_engine
  import sa_pkg::*;
#(
  parameter int DW   = 8,
  parameter int N    = 3,
  parameter int ACCW = 2*DW + clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic                  ld_sel,
  input  logic [clog2(N)-1:0]   ld_row,
  input  logic [N*DW-1:0]       ld_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [clog2(N)-1:0]   out_row,
  output logic [N*ACCW-1:0]     out_data,
  output logic                  done
);

  localparam int RW = clog2(N);
  localparam int TW = clog2(3*N);
  localparam logic [TW-1:0] T_LAST  = TW'(3*N - 3);
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

  sa_state_e        state_q;
  logic [TW-1:0]    t_q;
  logic [RW-1:0]    out_row_q;
  logic [N*ACCW-1:0] out_data_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [DW-1:0]    a_q [N][N];
  logic [DW-1:0]    b_q [N][N];

  logic             clear_w;
  logic [DW-1:0]    a_edge [N];
  logic [DW-1:0]    b_edge [N];
  logic [DW-1:0]    a_h [N][N+1];
  logic [DW-1:0]    b_v [N+1][N];
  logic [ACCW-1:0]  acc_w [N][N];

  logic [RW-1:0]    next_row;
  logic [N*ACCW-1:0] row_data_d;

  assign clear_w = (state_q == ST_IDLE) && start;

  // Operand buffers only accept writes while idle, so a running job sees a frozen A and B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
        end
      end
    end else if ((state_q == ST_IDLE) && ld_valid && (int'(ld_row) < N)) begin
      for (int j = 0; j < N; j++) begin
        if (ld_sel) b_q[ld_row][j] <= ld_data[j*DW +: DW];
        else        a_q[ld_row][j] <= ld_data[j*DW +: DW];
      end
    end
  end

  // Row i of A and column j of B are skewed by their index: element k enters at step k+i (k+j).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
    end
    if (state_q == ST_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_q) == i + k) begin
            a_edge[i] = a_q[i][k];
            b_edge[i] = b_q[k][i];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign a_h[gi][0] = a_edge[gi];
    assign b_v[0][gi] = b_edge[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      sa_mac_pe #(
        .DW   (DW),
        .ACCW (ACCW)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_w),
        .din   (a_h[gi][gj]),
        .win   (b_v[gi][gj]),
        .dout  (a_h[gi][gj+1]),
        .wout  (b_v[gi+1][gj]),
        .acc   (acc_w[gi][gj])
      );
    end
  end

  // Row about to be presented: row 0 on leaving DRAIN, otherwise the successor of the current row.
  always_comb begin
    next_row   = (state_q == ST_OUT) ? out_row_q + RW'(1) : '0;
    row_data_d = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(next_row) == i) begin
        for (int j = 0; j < N; j++) begin
          row_data_d[j*ACCW +: ACCW] = acc_w[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      out_row_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FEED;
            t_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_FEED: begin
          t_q <= t_q + TW'(1);
          if (t_q == T_LAST) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_q     <= ST_OUT;
          out_row_q   <= '0;
          out_data_q  <= row_data_d;
          out_valid_q <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) begin
            if (out_row_q == ROW_LAST) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_row_q  <= next_row;
              out_data_q <= row_data_d;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sa_nxn_engine.sv
// Directed and randomized bench for sa_nxn_engine: results are compared against
// a plain sum-of-products matrix model held in the bench.
module tb_sa_nxn_engine;

  localparam int DW    = 8;
  localparam int N     = 3;
  localparam int RW    = 2;
  localparam int ACCW  = 2*DW + 2;
  localparam int N2    = 2;
  localparam int ACCW2 = 2*DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              ld_valid, ld_sel, start, out_ready;
  logic [RW-1:0]     ld_row;
  logic [N*DW-1:0]   ld_data;
  logic              busy, out_valid, done;
  logic [RW-1:0]     out_row;
  logic [N*ACCW-1:0] out_data;

  logic                ld_valid2, ld_sel2, start2, out_ready2;
  logic [0:0]          ld_row2;
  logic [N2*DW-1:0]    ld_data2;
  logic                busy2, out_valid2, done2;
  logic [0:0]          out_row2;
  logic [N2*ACCW2-1:0] out_data2;

  int compared = 0;
  int mismatched = 0;
  int unsigned ma [N][N];
  int unsigned mb [N][N];

  sa_nxn_engine #(.DW(DW), .N(N), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_row(ld_row),
    .ld_data(ld_data), .start(start), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_data(out_data), .done(done)
  );

  sa_nxn_engine #(.DW(DW), .N(N2), .ACCW(ACCW2)) dut2 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid2), .ld_sel(ld_sel2), .ld_row(ld_row2),
    .ld_data(ld_data2), .start(start2), .busy(busy2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_row(out_row2), .out_data(out_data2), .done(done2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] packRow(input logic sel, input int r);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = sel ? DW'(mb[r][j]) : DW'(ma[r][j]);
    return v;
  endfunction

  // C[r][j] = sum over k of A[r][k]*B[k][j], reduced modulo 2^ACCW.
  function automatic logic [N*ACCW-1:0] expRow(input int r);
    logic [N*ACCW-1:0] v;
    longint unsigned s;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += longint'(ma[r][k]) * longint'(mb[k][j]);
      s = s % (64'd1 << ACCW);
      v[j*ACCW +: ACCW] = ACCW'(s);
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic sel, input int row, input logic [N*DW-1:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_row   = RW'(row);
    ld_data  = data;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic loadAll();
    for (int i = 0; i < N; i++) applyStimulus(1'b0, i, packRow(1'b0, i));
    for (int i = 0; i < N; i++) applyStimulus(1'b1, i, packRow(1'b1, i));
  endtask

  // mode 0: plain run; 1: start/ld_valid pulsed mid-FEED; 2: B row 2 written on the start cycle.
  task automatic runCompute(input string tag, input int mode, input int stallRow, input int stallCycles);
    int cycles;
    start = 1'b1;
    if (mode == 2) begin
      ld_valid = 1'b1; ld_sel = 1'b1; ld_row = RW'(2); ld_data = packRow(1'b1, 2);
    end
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b0;
    cycles = 1;
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    while (!out_valid && cycles < 100) begin
      if (mode == 1 && cycles == 2) begin
        start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_row = '0; ld_data = '1;
      end
      @(negedge clk);
      cycles++;
      start = 1'b0; ld_valid = 1'b0;
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(3*N));
    for (int r = 0; r < N; r++) begin
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_row"}, 64'(out_row), 64'(r));
      checkOutput({tag, "_data"}, 64'(out_data), 64'(expRow(r)));
      if (r == stallRow) begin
        out_ready = 1'b0;
        repeat (stallCycles) begin
          @(negedge clk);
          checkOutput({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
          checkOutput({tag, "_stall_row"}, 64'(out_row), 64'(r));
          checkOutput({tag, "_stall_data"}, 64'(out_data), 64'(expRow(r)));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_idle_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic randomize_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = $urandom_range(0, 255);
        mb[i][j] = $urandom_range(0, 255);
      end
  endtask

  initial begin
    int cycles2;
    rst = 1'b1;
    ld_valid = 0; ld_sel = 0; ld_row = '0; ld_data = '0; start = 0; out_ready = 1'b1;
    ld_valid2 = 0; ld_sel2 = 0; ld_row2 = '0; ld_data2 = '0; start2 = 0; out_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_row", 64'(out_row), 64'd0);
    checkOutput("rst_data", 64'(out_data), 64'd0);
    checkOutput("rst_busy2", 64'(busy2), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = 3*i + j + 1;
      end
    loadAll();
    runCompute("ident", 0, -1, 0);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 255;
        mb[i][j] = 255;
      end
    loadAll();
    runCompute("max", 0, -1, 0);

    randomize_model();
    loadAll();
    runCompute("stall", 0, 1, 5);

    runCompute("ignore_feed", 1, -1, 0);
    runCompute("repeat", 0, -1, 0);

    applyStimulus(1'b0, 3, '1);
    runCompute("oor_row", 0, -1, 0);

    for (int j = 0; j < N; j++) mb[2][j] = $urandom_range(0, 255);
    runCompute("simul_ld", 2, -1, 0);

    // Abort mid-FEED at step t=3 (fourth cycle after the start edge).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    runCompute("post_rst_zero", 0, -1, 0);
    randomize_model();
    loadAll();
    runCompute("post_rst", 0, -1, 0);

    for (int it = 0; it < 3; it++) begin
      randomize_model();
      loadAll();
      runCompute($sformatf("rand%0d", it), 0, int'($urandom_range(0, N-1)), int'($urandom_range(0, 3)));
    end

    // N=2 build: A={1,2},{3,4}, B={5,6},{7,8} -> C={19,22},{43,50}.
    ld_valid2 = 1'b1;
    ld_sel2 = 1'b0; ld_row2 = 1'b0; ld_data2 = {8'd2, 8'd1}; @(negedge clk);
    ld_sel2 = 1'b0; ld_row2 = 1'b1; ld_data2 = {8'd4, 8'd3}; @(negedge clk);
    ld_sel2 = 1'b1; ld_row2 = 1'b0; ld_data2 = {8'd6, 8'd5}; @(negedge clk);
    ld_sel2 = 1'b1; ld_row2 = 1'b1; ld_data2 = {8'd8, 8'd7}; @(negedge clk);
    ld_valid2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cycles2 = 1;
    while (!out_valid2 && cycles2 < 100) begin
      @(negedge clk);
      cycles2++;
    end
    checkOutput("n2_latency", 64'(cycles2), 64'd6);
    checkOutput("n2_row0", 64'(out_data2), 64'({17'd22, 17'd19}));
    @(negedge clk);
    checkOutput("n2_rowidx1", 64'(out_row2), 64'd1);
    checkOutput("n2_row1", 64'(out_data2), 64'({17'd50, 17'd43}));
    @(negedge clk);
    checkOutput("n2_done", 64'(done2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
